// File: rtl/spi_controller.sv
// SPI mode-0 bus initiator: byte-wide valid/ready in, SCLK/CS_n/COPI out, CIPO byte back.
// Multi-byte frames hold CS_n low between bytes until a byte flagged last completes.
module spi_controller #(
   parameter int CLKS_PER_HALF_BIT = 4,
   parameter int CS_INACTIVE_CLKS  = 2
) (
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic [7:0] i_tx_byte,
   input  logic       i_tx_dv,
   input  logic       i_tx_last,
   output logic       o_tx_ready,
   output logic [7:0] o_rx_byte,
   output logic       o_rx_dv,
   output logic       o_spi_clk,
   input  logic       i_spi_cipo,
   output logic       o_spi_copi,
   output logic       o_spi_cs_n
);

   localparam int HW = $clog2(CLKS_PER_HALF_BIT + 1);
   localparam int CW = $clog2(CS_INACTIVE_CLKS + 1);
   localparam logic [HW-1:0] HALF_LAST = HW'(CLKS_PER_HALF_BIT - 1);
   localparam logic [CW-1:0] CS_LAST   = CW'(CS_INACTIVE_CLKS - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_SHIFT  = 3'd2,
      ST_HOLD   = 3'd3,
      ST_CS_OFF = 3'd4
   } state_t;

   state_t        state_r, state_nx_s;
   logic [HW-1:0] half_r, half_nx_s;
   logic [2:0]    bit_r, bit_nx_s;
   logic          high_r, high_nx_s;
   logic [CW-1:0] cs_cnt_r, cs_cnt_nx_s;
   logic [7:0]    tx_r, tx_nx_s;
   logic          last_r, last_nx_s;
   logic [7:0]    shreg_r, shreg_nx_s;
   logic          cs_n_r, cs_n_nx_s;
   logic          sclk_r, sclk_nx_s;
   logic          copi_r, copi_nx_s;
   logic          ready_r, ready_nx_s;
   logic [7:0]    rx_byte_r, rx_byte_nx_s;
   logic          rx_dv_r, rx_dv_nx_s;
   logic          accept_s;

   assign accept_s = i_tx_dv & ready_r;

   // State, counters, datapath and registered pin values.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_r   <= ST_IDLE;
         half_r    <= '0;
         bit_r     <= 3'd0;
         high_r    <= 1'b0;
         cs_cnt_r  <= '0;
         tx_r      <= 8'h00;
         last_r    <= 1'b0;
         shreg_r   <= 8'h00;
         cs_n_r    <= 1'b1;
         sclk_r    <= 1'b0;
         copi_r    <= 1'b0;
         ready_r   <= 1'b1;
         rx_byte_r <= 8'h00;
         rx_dv_r   <= 1'b0;
      end else begin
         state_r   <= state_nx_s;
         half_r    <= half_nx_s;
         bit_r     <= bit_nx_s;
         high_r    <= high_nx_s;
         cs_cnt_r  <= cs_cnt_nx_s;
         tx_r      <= tx_nx_s;
         last_r    <= last_nx_s;
         shreg_r   <= shreg_nx_s;
         cs_n_r    <= cs_n_nx_s;
         sclk_r    <= sclk_nx_s;
         copi_r    <= copi_nx_s;
         ready_r   <= ready_nx_s;
         rx_byte_r <= rx_byte_nx_s;
         rx_dv_r   <= rx_dv_nx_s;
      end
   end

   // Next state; pin values are computed one cycle ahead so every output is a flop.
   always_comb begin
      state_nx_s   = state_r;
      half_nx_s    = half_r;
      bit_nx_s     = bit_r;
      high_nx_s    = high_r;
      cs_cnt_nx_s  = cs_cnt_r;
      tx_nx_s      = tx_r;
      last_nx_s    = last_r;
      shreg_nx_s   = shreg_r;
      cs_n_nx_s    = cs_n_r;
      sclk_nx_s    = sclk_r;
      copi_nx_s    = copi_r;
      ready_nx_s   = ready_r;
      rx_byte_nx_s = rx_byte_r;
      rx_dv_nx_s   = 1'b0;
      case (state_r)
         ST_IDLE, ST_HOLD: begin
            if (accept_s) begin
               state_nx_s = ST_SETUP;
               half_nx_s  = '0;
               tx_nx_s    = i_tx_byte;
               last_nx_s  = i_tx_last;
               cs_n_nx_s  = 1'b0;
               sclk_nx_s  = 1'b0;
               copi_nx_s  = i_tx_byte[7];
               ready_nx_s = 1'b0;
            end else begin
               state_nx_s = state_r;
            end
         end
         ST_SETUP: begin
            if (half_r == HALF_LAST) begin
               state_nx_s = ST_SHIFT;
               half_nx_s  = '0;
               bit_nx_s   = 3'd0;
               high_nx_s  = 1'b1;
               sclk_nx_s  = 1'b1;
            end else begin
               half_nx_s = half_r + HW'(1'b1);
            end
         end
         ST_SHIFT: begin
            if (half_r != HALF_LAST) begin
               half_nx_s = half_r + HW'(1'b1);
            end else if (high_r) begin
               // End of a high phase: sample CIPO, drop SCLK, present the next bit.
               half_nx_s  = '0;
               high_nx_s  = 1'b0;
               sclk_nx_s  = 1'b0;
               shreg_nx_s = {shreg_r[6:0], i_spi_cipo};
               if (bit_r == 3'd7) begin
                  rx_dv_nx_s   = 1'b1;
                  rx_byte_nx_s = {shreg_r[6:0], i_spi_cipo};
               end else begin
                  copi_nx_s = tx_r[3'd6 - bit_r];
               end
            end else if (bit_r != 3'd7) begin
               half_nx_s = '0;
               high_nx_s = 1'b1;
               sclk_nx_s = 1'b1;
               bit_nx_s  = bit_r + 3'd1;
            end else if (last_r) begin
               state_nx_s  = ST_CS_OFF;
               cs_cnt_nx_s = '0;
               cs_n_nx_s   = 1'b1;
               copi_nx_s   = 1'b0;
            end else begin
               state_nx_s = ST_HOLD;
               ready_nx_s = 1'b1;
            end
         end
         ST_CS_OFF: begin
            if (cs_cnt_r == CS_LAST) begin
               state_nx_s = ST_IDLE;
               ready_nx_s = 1'b1;
            end else begin
               cs_cnt_nx_s = cs_cnt_r + CW'(1'b1);
            end
         end
         default: begin
            state_nx_s = ST_IDLE;
            cs_n_nx_s  = 1'b1;
            sclk_nx_s  = 1'b0;
            copi_nx_s  = 1'b0;
            ready_nx_s = 1'b1;
         end
      endcase
   end

   assign o_tx_ready = ready_r;
   assign o_rx_byte  = rx_byte_r;
   assign o_rx_dv    = rx_dv_r;
   assign o_spi_clk  = sclk_r;
   assign o_spi_copi = copi_r;
   assign o_spi_cs_n = cs_n_r;

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller (T=4, C=2): directed table, HOLD stall, random bytes, mid-transfer reset.
// Expected pin values per cycle come from the accept-relative timing formulas.
module tb_spi_controller;

   localparam int T = 4;
   localparam int C = 2;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [7:0] tx_byte;
   logic       tx_dv;
   logic       tx_last;
   logic       tx_ready;
   logic [7:0] rx_byte;
   logic       rx_dv;
   logic       spi_clk;
   logic       spi_cipo;
   logic       spi_copi;
   logic       spi_cs_n;

   int total = 0;
   int bad   = 0;

   // Peripheral model: bit j of the whole response stream is shown after the j-th SCLK fall.
   logic resp_bits [0:4095];
   int   fall_cnt  = 0;
   logic sclk_prev = 1'b0;

   spi_controller #(.CLKS_PER_HALF_BIT(T), .CS_INACTIVE_CLKS(C)) dut (
      .i_clk      (clk),
      .i_reset_n  (reset_n),
      .i_tx_byte  (tx_byte),
      .i_tx_dv    (tx_dv),
      .i_tx_last  (tx_last),
      .o_tx_ready (tx_ready),
      .o_rx_byte  (rx_byte),
      .o_rx_dv    (rx_dv),
      .o_spi_clk  (spi_clk),
      .i_spi_cipo (spi_cipo),
      .o_spi_copi (spi_copi),
      .o_spi_cs_n (spi_cs_n)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (sclk_prev && !spi_clk) fall_cnt = fall_cnt + 1;
      sclk_prev = spi_clk;
   end

   assign spi_cipo = resp_bits[fall_cnt % 4096];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Send one byte accepted at cycle 0 and check every pin for each following cycle.
   task automatic send(input logic [7:0] b, input logic l, input logic [7:0] resp);
      int nend;
      int base;
      int m;
      int k0;
      int idx;
      bit hi;
      chk("ready_before_accept", 8'(tx_ready), 8'd1);
      base = fall_cnt;
      for (int i = 0; i < 8; i++) resp_bits[(base + i) % 4096] = resp[3'(7 - i)];
      tx_byte = b;
      tx_last = l;
      tx_dv   = 1'b1;
      nend = l ? 17*T + C + 1 : 17*T + 1;
      @(posedge clk);
      for (int n = 1; n <= nend; n++) begin
         @(negedge clk);
         hi = 1'b0;
         if (n > T && n <= 17*T) begin
            m  = n - T - 1;
            k0 = m / (2*T);
            hi = (m % (2*T)) < T;
            idx = hi ? 7 - k0 : ((k0 == 7) ? 0 : 6 - k0);
         end else begin
            idx = 7;
         end
         chk($sformatf("cs_n@%0d", n), 8'(spi_cs_n), (n <= 17*T) ? 8'd0 : 8'(l));
         chk($sformatf("sclk@%0d", n), 8'(spi_clk), 8'(hi));
         chk($sformatf("ready@%0d", n), 8'(tx_ready), (n == nend) ? 8'd1 : 8'd0);
         chk($sformatf("rx_dv@%0d", n), 8'(rx_dv), (n == 16*T + 1) ? 8'd1 : 8'd0);
         if (n <= 17*T) chk($sformatf("copi@%0d", n), 8'(spi_copi), 8'(b[3'(idx)]));
         if (n == 16*T + 1) chk("rx_byte", rx_byte, resp);
         if (n < nend) begin
            tx_dv   = 1'($urandom);
            tx_byte = 8'($urandom);
            tx_last = 1'($urandom);
         end
      end
   endtask

   typedef struct {
      logic [7:0] tx;
      logic       last;
      logic [7:0] rx;
   } vec_t;

   vec_t vecs [6];

   initial begin
      logic [7:0] rb;
      logic [7:0] rr;
      logic       rl;
      for (int i = 0; i < 4096; i++) resp_bits[i] = 1'b0;
      vecs[0] = '{8'hA5, 1'b1, 8'h3C};
      vecs[1] = '{8'h12, 1'b0, 8'hC3};
      vecs[2] = '{8'hFE, 1'b1, 8'h7E};
      vecs[3] = '{8'h01, 1'b0, 8'hFE};
      vecs[4] = '{8'h02, 1'b0, 8'h01};
      vecs[5] = '{8'h03, 1'b1, 8'h02};
      tx_dv = 1'b0; tx_byte = 8'h00; tx_last = 1'b0; reset_n = 1'b0;

      repeat (3) @(negedge clk);
      chk("rst_cs_n", 8'(spi_cs_n), 8'd1);
      chk("rst_sclk", 8'(spi_clk), 8'd0);
      chk("rst_copi", 8'(spi_copi), 8'd0);
      chk("rst_ready", 8'(tx_ready), 8'd1);
      chk("rst_rx_dv", 8'(rx_dv), 8'd0);
      chk("rst_rx_byte", rx_byte, 8'h00);
      reset_n = 1'b1;
      @(negedge clk);

      for (int v = 0; v < 6; v++) send(vecs[v].tx, vecs[v].last, vecs[v].rx);
      tx_dv = 1'b0;

      send(8'h55, 1'b0, 8'hAA);
      tx_dv = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         chk("hold_cs_n", 8'(spi_cs_n), 8'd0);
         chk("hold_sclk", 8'(spi_clk), 8'd0);
         chk("hold_ready", 8'(tx_ready), 8'd1);
      end
      send(8'h00, 1'b1, 8'h81);
      tx_dv = 1'b0;

      for (int i = 0; i < 40; i++) begin
         rb = 8'($urandom);
         rr = 8'($urandom);
         rl = (i == 39) ? 1'b1 : 1'($urandom);
         send(rb, rl, rr);
      end
      tx_dv = 1'b0;

      @(negedge clk);
      tx_byte = 8'hC3; tx_last = 1'b1; tx_dv = 1'b1;
      @(posedge clk);
      #1 tx_dv = 1'b0;
      repeat (29) @(posedge clk);
      #1 chk("sclk_before_reset", 8'(spi_clk), 8'd1);
      #1 reset_n = 1'b0;
      #1;
      chk("midrst_cs_n", 8'(spi_cs_n), 8'd1);
      chk("midrst_sclk", 8'(spi_clk), 8'd0);
      chk("midrst_rx_dv", 8'(rx_dv), 8'd0);
      repeat (3) begin
         @(negedge clk);
         chk("midrst_rx_dv_hold", 8'(rx_dv), 8'd0);
      end
      reset_n = 1'b1;
      @(negedge clk);
      chk("postrst_ready", 8'(tx_ready), 8'd1);
      chk("postrst_cs_n", 8'(spi_cs_n), 8'd1);
      send(8'h5A, 1'b1, 8'h96);
      tx_dv = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
